neuron_mac_seq: RTL and testbench

NEURON_MAC_SEQ -- requirements
Module: neuron_mac_seq

---
 rtl/neuron_mac_seq.sv | 114 +++++++++++
 tb/tb_neuron_mac_seq.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/neuron_mac_seq.sv
// Sequential fixed-point neuron: one MAC per cycle over N_IN inputs, bias preload, ReLU output.
// Optional output saturation is enabled by defining NEURON_MAC_SAT_EN (default build wraps).
module neuron_mac_seq #(
    parameter int N_IN = 15,
    parameter int DW   = 16,
    parameter int FRAC = 8
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [N_IN*DW-1:0]          in_data,
    input  logic                        w_we,
    input  logic [$clog2(N_IN+1)-1:0]   w_addr,
    input  logic [DW-1:0]               w_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [DW-1:0]               out_data
);
    localparam int IW = $clog2(N_IN + 1);
    localparam int AW = 2 * DW + IW;
    localparam logic signed [AW-1:0] MAXV = {{(AW-DW+1){1'b0}}, {(DW-1){1'b1}}};

    typedef enum logic [1:0] {IDLE, MAC, OUT} state_t;

    state_t                state_q, state_d;
    logic [DW-1:0]         x_q [N_IN];
    logic [DW-1:0]         w_q [N_IN+1];
    logic signed [AW-1:0]  acc_q;
    logic [IW-1:0]         idx_q;
    logic [DW-1:0]         out_q;

    logic                  wr_ok;
    logic [DW-1:0]         bias_eff;
    logic signed [AW-1:0]  bias_ext;
    logic [DW-1:0]         x_sel, w_sel;
    logic signed [2*DW-1:0] prod;
    logic signed [AW-1:0]  prod_ext;
    logic signed [AW-1:0]  shifted, relu;
    logic [DW-1:0]         res;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid) state_d = MAC;
            MAC:     if (idx_q == IW'(N_IN)) state_d = OUT;
            OUT:     if (out_ready) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    assign in_ready  = (state_q == IDLE);
    assign out_valid = (state_q == OUT);
    assign out_data  = out_q;

    // A bias written on the accepting edge must already seed this vector's accumulator.
    assign wr_ok    = (state_q == IDLE) && w_we && (w_addr <= IW'(N_IN));
    assign bias_eff = (wr_ok && (w_addr == IW'(N_IN))) ? w_data : w_q[N_IN];
    assign bias_ext = {{(AW-DW){bias_eff[DW-1]}}, bias_eff} <<< FRAC;

    always_comb begin
        x_sel = '0;
        w_sel = '0;
        for (int i = 0; i < N_IN; i++) begin
            if (idx_q == IW'(i)) begin
                x_sel = x_q[i];
                w_sel = w_q[i];
            end
        end
    end

    assign prod     = $signed(x_sel) * $signed(w_sel);
    assign prod_ext = {{IW{prod[2*DW-1]}}, prod};
    assign shifted  = acc_q >>> FRAC;
    assign relu     = shifted[AW-1] ? '0 : shifted;

`ifdef NEURON_MAC_SAT_EN
    assign res = (relu > MAXV) ? DW'(MAXV) : DW'(relu);
`else
    assign res = DW'(relu);
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < N_IN; i++) x_q[i] <= '0;
            for (int i = 0; i <= N_IN; i++) w_q[i] <= '0;
            acc_q <= '0;
            idx_q <= '0;
            out_q <= '0;
        end else begin
            if (wr_ok) w_q[w_addr] <= w_data;
            case (state_q)
                IDLE: if (in_valid) begin
                    for (int i = 0; i < N_IN; i++) x_q[i] <= in_data[i*DW +: DW];
                    acc_q <= bias_ext;
                    idx_q <= '0;
                end
                // idx runs one past the last term; that extra edge registers the result.
                MAC: if (idx_q != IW'(N_IN)) begin
                    acc_q <= acc_q + prod_ext;
                    idx_q <= idx_q + 1'b1;
                end else begin
                    out_q <= res;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_neuron_mac_seq.sv
// Self-checking bench for neuron_mac_seq: vector table, scoreboard queue, and hand sequences
// for reset abort, backpressure and same-edge coefficient write.
module tb_neuron_mac_seq;
    localparam int N  = 15;
    localparam int DW = 16;
    localparam int IW = $clog2(N + 1);

    logic              clk = 1'b0;
    logic              reset;
    logic              in_valid;
    logic              in_ready;
    logic [N*DW-1:0]   in_data;
    logic              w_we;
    logic [IW-1:0]     w_addr;
    logic [DW-1:0]     w_data;
    logic              out_valid;
    logic              out_ready;
    logic [DW-1:0]     out_data;

    int n_cmp = 0;
    int n_err = 0;
    logic [DW-1:0] exp_q[$];

    typedef struct {
        logic [DW-1:0] w;
        logic [DW-1:0] x;
        logic [DW-1:0] b;
        logic [DW-1:0] e;
    } vec_t;
    vec_t tbl[7];

    neuron_mac_seq #(.N_IN(N), .DW(DW), .FRAC(8)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .w_we(w_we), .w_addr(w_addr), .w_data(w_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Scoreboard: every handshaken result is matched against the oldest expectation.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected result: got %h expected none", out_data);
            end else begin
                chk("result", {16'h0, out_data}, {16'h0, exp_q.pop_front()});
            end
        end
    end

    task automatic set_x(input logic [DW-1:0] x);
        for (int i = 0; i < N; i++) in_data[i*DW +: DW] = x;
    endtask

    task automatic wr(input int a, input logic [DW-1:0] d);
        w_we = 1'b1; w_addr = IW'(a); w_data = d;
        @(posedge clk); #1;
        w_we = 1'b0;
    endtask

    task automatic load(input logic [DW-1:0] w, input logic [DW-1:0] b);
        for (int a = 0; a < N; a++) wr(a, w);
        wr(N, b);
    endtask

    task automatic wait_out(output int lat);
        lat = 0;
        while (!out_valid && lat < 40) begin
            @(posedge clk); #1;
            lat++;
        end
    endtask

    task automatic run_vec(input logic [DW-1:0] x, input logic [DW-1:0] e, input string nm);
        int lat;
        set_x(x);
        in_valid = 1'b1;
        exp_q.push_back(e);
        @(posedge clk); #1;
        in_valid = 1'b0;
        w_we = 1'b0;
        wait_out(lat);
        chk({nm, " latency"}, lat, 16);
        if (!out_valid) void'(exp_q.pop_back());
        @(posedge clk); #1;
        chk({nm, " in_ready after handshake"}, {31'h0, in_ready}, 32'h1);
    endtask

    initial begin
        int lat;
        int seen;
        reset = 1'b1; in_valid = 1'b0; in_data = '0; w_we = 1'b0;
        w_addr = '0; w_data = '0; out_ready = 1'b1;

        tbl[0] = '{w:16'h0100, x:16'h0100, b:16'h0000, e:16'h0F00};
        tbl[1] = '{w:16'hFF00, x:16'h0100, b:16'h0200, e:16'h0000};
`ifdef NEURON_MAC_SAT_EN
        tbl[2] = '{w:16'h7FFF, x:16'h7FFF, b:16'h0000, e:16'h7FFF};
`else
        tbl[2] = '{w:16'h7FFF, x:16'h7FFF, b:16'h0000, e:16'hF100};
`endif
        tbl[3] = '{w:16'h0080, x:16'h0200, b:16'h0100, e:16'h1000};
        tbl[4] = '{w:16'h0100, x:16'hFF80, b:16'h0A00, e:16'h0280};
        tbl[5] = '{w:16'h0010, x:16'h0010, b:16'h0000, e:16'h000F};
        tbl[6] = '{w:16'hFFFF, x:16'h0001, b:16'h0000, e:16'h0000};

        @(posedge clk); @(posedge clk); #1;
        reset = 1'b0;
        chk("reset in_ready", {31'h0, in_ready}, 32'h1);
        chk("reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("reset out_data", {16'h0, out_data}, 32'h0);

        // Abort in OUT: result held, then async reset clears outputs immediately.
        load(16'h0100, 16'h0300);
        out_ready = 1'b0;
        set_x(16'h0100);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("held result before reset", {16'h0, out_data}, 32'h1200);
        #2 reset = 1'b1;
        #1;
        chk("async reset out_valid", {31'h0, out_valid}, 32'h0);
        chk("async reset out_data", {16'h0, out_data}, 32'h0);
        chk("async reset in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        out_ready = 1'b1;
        run_vec(16'h0100, 16'h0000, "cleared coefs");

        // Abort in MAC: nothing may come out afterwards.
        load(16'h0100, 16'h0000);
        set_x(16'h0100);
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1 reset = 1'b1;
        #1;
        chk("mid-MAC reset in_ready", {31'h0, in_ready}, 32'h1);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 0;
        repeat (20) begin
            @(posedge clk); #1;
            if (out_valid) seen++;
        end
        chk("no result after abort", seen, 0);

        for (int i = 0; i < 7; i++) begin
            load(tbl[i].w, tbl[i].b);
            run_vec(tbl[i].x, tbl[i].e, $sformatf("vec%0d", i));
        end

        // Same-edge weight write is used by the vector accepted on that edge.
        load(16'h0100, 16'h0000);
        w_we = 1'b1; w_addr = IW'(3); w_data = 16'h0200;
        run_vec(16'h0100, 16'h1000, "same-edge weight");
        load(16'h0100, 16'h0000);
        w_we = 1'b1; w_addr = IW'(N); w_data = 16'h0100;
        run_vec(16'h0100, 16'h1000, "same-edge bias");

        // Backpressure: output held, new vectors and writes ignored.
        load(16'h0100, 16'h0000);
        out_ready = 1'b0;
        set_x(16'h0100);
        in_valid = 1'b1;
        exp_q.push_back(16'h0F00);
        @(posedge clk); #1;
        in_valid = 1'b0;
        wait_out(lat);
        chk("bp latency", lat, 16);
        for (int c = 0; c < 5; c++) begin
            in_valid = 1'b1; set_x(16'h0200);
            w_we = 1'b1; w_addr = IW'(c); w_data = 16'h7000;
            @(posedge clk); #1;
            chk("bp out_data stable", {16'h0, out_data}, 32'h0F00);
            chk("bp in_ready low", {31'h0, in_ready}, 32'h0);
            chk("bp out_valid held", {31'h0, out_valid}, 32'h1);
        end
        in_valid = 1'b0; w_we = 1'b0; out_ready = 1'b1;
        @(posedge clk); #1;
        chk("bp in_ready after handshake", {31'h0, in_ready}, 32'h1);
        chk("bp out_valid after handshake", {31'h0, out_valid}, 32'h0);
        run_vec(16'h0100, 16'h0F00, "coefs unchanged");

        repeat (3) @(posedge clk);
        chk("scoreboard drained", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
